drum_word_reader: RTL and testbench
===================================

DRUM_WORD_READER -- requirements
Module: drum_word_reader

Interface
REQ-001 SHALL provide parameter WORD_BITS, default 29, bits per drum word.
REQ-002 SHALL provide parameter LINE_WORDS, default 108, words per recirculating line.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  reader enable; low forces IDLE.
REQ-006 SHALL have port bit_strobe  input  1  qualifies one bit time; bit_in sampled only when high.
REQ-007 SHALL have port bit_in  input  1  serial drum data, LSB first.
REQ-008 SHALL have port word_start  input  1  marks bit 0 (T0) of a word; meaningful only with bit_strobe.
REQ-009 SHALL have port line_start  input  1  marks word 0 of the line; meaningful only with word_start and bit_strobe.
REQ-010 SHALL have port word_out  output  WORD_BITS  last completed word, bit k = k-th serial bit.
REQ-011 SHALL have port word_valid  output  1  one-cycle pulse when word_out updates.
REQ-012 SHALL have port word_addr  output  $clog2(LINE_WORDS)  word-time index of word_out.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on framing violation.

Function
REQ-014 SHALL implement states IDLE, HUNT, SHIFT; IDLE->HUNT when en=1.
REQ-015 In HUNT, strobe with word_start SHALL capture bit_in as bit 0, set bit count 1, enter SHIFT; strobe without word_start ignored.
REQ-016 In SHIFT, each strobe without word_start SHALL store bit_in at current bit count and increment it.
REQ-017 Strobe storing bit WORD_BITS-1 SHALL cause word_out load and word_valid=1 on the next clk (latency one cycle after final strobe); state stays SHIFT with bit count 0, expecting word_start.
REQ-018 Back-to-back words: strobe with word_start at bit count 0 SHALL begin next word with no gap and no error.
REQ-019 Strobe without word_start at bit count 0 after a completed word SHALL pulse frame_err, discard the bit, enter HUNT.
REQ-020 word_start at bit count 1..WORD_BITS-1 SHALL pulse frame_err, discard partial word, capture that bit as bit 0 of a new word (stay SHIFT).
REQ-021 Partial words SHALL never update word_out or pulse word_valid.
REQ-022 en=0 in any state SHALL enter IDLE next clk, discard partial word, no word_valid, no frame_err; word_out retains value.
REQ-023 Cycles with bit_strobe=0 SHALL not change bit count, shift data, or state (except en/rst).
REQ-024 word_valid and frame_err SHALL never assert in the same cycle; frame_err takes priority if both apply.

Reset
REQ-025 rst=1 SHALL force state IDLE, bit count 0, word_out=0, word_addr=0, word_valid=0, frame_err=0, overriding en and all strobes.
REQ-026 rst deasserted mid-line SHALL require a new word_start before any capture.

Configuration
REQ-027 Macro G15_WORD_ADDR_EN defined: word counter counts completed words, wraps LINE_WORDS-1->0, is cleared to 0 by line_start at bit 0, and word_addr presents the counter value belonging to the word on word_out during word_valid.
REQ-028 Macro G15_WORD_ADDR_EN undefined: no word counter, word_addr tied 0, line_start ignored.

Verification
REQ-029 rst, en=1, serial 29 bits of 0x1555_5555 & mask with word_start on bit 0 -> word_valid one cycle after 29th strobe, word_out=0x15555555.
REQ-030 Two contiguous words 0x0000001 then 0x1FFFFFFF, no strobe gap -> two word_valid pulses 29 strobes apart, values in order, frame_err never.
REQ-031 word_start injected at bit 10 -> frame_err pulse, no word_valid, following 29 bits captured correctly as new word.
REQ-032 en dropped at bit 15 then restored, full word sent -> no word_valid/frame_err for aborted word; next word valid.
REQ-033 G15_WORD_ADDR_EN: line_start on word 0, 109 words sent -> word_addr 0..107 then 0; undefined -> word_addr always 0.
REQ-034 rst asserted at bit 20 of a word -> all outputs 0 next clk; bits before next word_start ignored.

Source files
------------

// File: rtl/drum_word_reader.sv
// Serial drum word reader: hunts for T0, assembles LSB-first words, flags framing errors.
// Optional word-time counter enabled by defining G15_WORD_ADDR_EN.
module drum_word_reader #(
  parameter int WORD_BITS  = 29,
  parameter int LINE_WORDS = 108
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          bit_strobe,
  input  logic                          bit_in,
  input  logic                          word_start,
  input  logic                          line_start,
  output logic [WORD_BITS-1:0]          word_out,
  output logic                          word_valid,
  output logic [$clog2(LINE_WORDS)-1:0] word_addr,
  output logic                          frame_err
);

  localparam int CNT_W  = $clog2(WORD_BITS);
  localparam int ADDR_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

  typedef enum logic [1:0] {IDLE, HUNT, SHIFT} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_BITS-1:0] shreg;
  logic                 store;
  logic                 start;
  logic                 load;
  logic                 err;
  logic [CNT_W-1:0]     store_idx;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store   = 1'b0;
    start   = 1'b0;
    load    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = HUNT;
      end
      HUNT: begin
        if (bit_strobe && word_start) begin
          store   = 1'b1;
          start   = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_strobe) begin
          if (word_start) begin
            // T0 mid-word: drop the partial word and restart on this bit.
            err   = (cnt_q != '0);
            store = 1'b1;
            start = 1'b1;
            cnt_d = CNT_W'(1);
          end else if (cnt_q == '0) begin
            err     = 1'b1;
            state_d = HUNT;
          end else begin
            store = 1'b1;
            if (cnt_q == LAST_BIT) begin
              load  = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      store   = 1'b0;
      start   = 1'b0;
      load    = 1'b0;
      err     = 1'b0;
    end
  end

  assign store_idx = start ? '0 : cnt_q;

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_err  <= err;
      word_valid <= load && !err;
      if (load && !err) begin
        word_out <= {bit_in, shreg[WORD_BITS-2:0]};
      end
    end
  end

  // NOTE: the assembly register carries no reset; every bit is rewritten before a word can complete.
  always_ff @(posedge clk) begin
    if (store) begin
      shreg[store_idx] <= bit_in;
    end
  end

`ifdef G15_WORD_ADDR_EN
  logic [ADDR_W-1:0] word_cnt;

  // word_cnt is the word-time index of the word being assembled.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt  <= '0;
      word_addr <= '0;
    end else if (start && line_start) begin
      word_cnt <= '0;
    end else if (load && !err) begin
      word_addr <= word_cnt;
      word_cnt  <= (word_cnt == ADDR_W'(LINE_WORDS - 1)) ? '0 : word_cnt + ADDR_W'(1);
    end
  end
`else
  logic unused_line_start;
  assign unused_line_start = line_start;
  assign word_addr         = '0;
`endif

endmodule

// File: tb/tb_drum_word_reader.sv
// Directed self-checking bench for drum_word_reader (29-bit words, 108-word line).
module tb_drum_word_reader;

  localparam int WB = 29;
  localparam int LW = 108;

  logic          clk = 1'b0;
  logic          rst, en, bit_strobe, bit_in, word_start, line_start;
  logic [WB-1:0] word_out;
  logic          word_valid;
  logic [6:0]    word_addr;
  logic          frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;

  drum_word_reader #(.WORD_BITS(WB), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .en(en), .bit_strobe(bit_strobe), .bit_in(bit_in),
    .word_start(word_start), .line_start(line_start), .word_out(word_out),
    .word_valid(word_valid), .word_addr(word_addr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (word_valid) begin
      n_valid++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
    end
    if (frame_err) n_err++;
    if (word_valid && frame_err) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  // One strobed bit time followed by one non-strobe cycle.
  task automatic drive_bit(input logic b, input logic ws, input logic ls);
    bit_strobe = 1'b1;
    bit_in     = b;
    word_start = ws;
    line_start = ls;
    idle_cyc(1);
    bit_strobe = 1'b0;
    bit_in     = 1'b0;
    word_start = 1'b0;
    line_start = 1'b0;
    idle_cyc(1);
  endtask

  task automatic send_bits(input logic [WB-1:0] w, input int n, input logic ls);
    for (int i = 0; i < n; i++) drive_bit(w[i], i == 0, ls && (i == 0));
  endtask

  int v0, e0;
  logic [WB-1:0] w;
  logic [31:0] exp_addr;

  initial begin
    rst = 1'b1; en = 1'b1; bit_strobe = 1'b0; bit_in = 1'b0;
    word_start = 1'b0; line_start = 1'b0;

    // Reset overrides enable and strobes.
    idle_cyc(2);
    drive_bit(1'b1, 1'b1, 1'b1);
    chk("rst_word_out", 32'(word_out), 32'h0);
    chk("rst_valid", 32'(word_valid), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    chk("rst_addr", 32'(word_addr), 32'h0);
    chk("rst_no_pulses", 32'(n_valid + n_err), 32'h0);

    // Bits before any word_start are ignored, then a full word.
    rst = 1'b0;
    idle_cyc(1);
    for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0, 1'b0);
    chk("hunt_ignore_err", 32'(n_err), 32'h0);
    send_bits(29'h1555_5555, WB, 1'b0);
    chk("w1_valid_cnt", 32'(n_valid), 32'd1);
    chk("w1_word_out", 32'(word_out), 32'h1555_5555);
    chk("w1_addr", 32'(word_addr), 32'h0);

    // Back-to-back words.
    v0 = n_valid; e0 = n_err;
    send_bits(29'h000_0001, WB, 1'b0);
    chk("b2b_first", 32'(word_out), 32'h1);
    send_bits(29'h1FFF_FFFF, WB, 1'b0);
    chk("b2b_second", 32'(word_out), 32'h1FFF_FFFF);
    chk("b2b_valid_cnt", 32'(n_valid - v0), 32'd2);
    chk("b2b_no_err", 32'(n_err - e0), 32'd0);
    chk("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd58);

    // word_start at bit 10 restarts the word.
    v0 = n_valid; e0 = n_err;
    send_bits(29'h0F0F_0F0F, 10, 1'b0);
    send_bits(29'h0ABC_DEF1, WB, 1'b0);
    chk("restart_err", 32'(n_err - e0), 32'd1);
    chk("restart_valid", 32'(n_valid - v0), 32'd1);
    chk("restart_word", 32'(word_out), 32'h0ABC_DEF1);

    // Missing word_start after a completed word.
    v0 = n_valid; e0 = n_err;
    drive_bit(1'b1, 1'b0, 1'b0);
    chk("no_t0_err", 32'(n_err - e0), 32'd1);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0, 1'b0);
    chk("no_t0_hunt_quiet", 32'(n_err - e0), 32'd1);
    send_bits(29'h00C0_FFEE, WB, 1'b0);
    chk("no_t0_recover", 32'(word_out), 32'h00C0_FFEE);
    chk("no_t0_valid", 32'(n_valid - v0), 32'd1);

    // Enable dropped at bit 15.
    v0 = n_valid; e0 = n_err;
    send_bits(29'h1FFF_FFFF, 15, 1'b0);
    en = 1'b0;
    drive_bit(1'b1, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b0);
    chk("en_retain", 32'(word_out), 32'h00C0_FFEE);
    chk("en_quiet", 32'((n_valid - v0) + (n_err - e0)), 32'd0);
    en = 1'b1;
    idle_cyc(1);
    send_bits(29'h1234_5678, WB, 1'b0);
    chk("en_word", 32'(word_out), 32'h1234_5678);
    chk("en_valid", 32'(n_valid - v0), 32'd1);
    chk("en_no_err", 32'(n_err - e0), 32'd0);

    // Reset at bit 20.
    send_bits(29'h1FFF_FFFF, 20, 1'b0);
    rst = 1'b1;
    idle_cyc(1);
    chk("mid_rst_word", 32'(word_out), 32'h0);
    chk("mid_rst_flags", 32'({word_valid, frame_err}), 32'h0);
    chk("mid_rst_addr", 32'(word_addr), 32'h0);
    rst = 1'b0;
    v0 = n_valid; e0 = n_err;
    for (int i = 0; i < 8; i++) drive_bit(1'b1, 1'b0, 1'b0);
    chk("mid_rst_ignore", 32'((n_valid - v0) + (n_err - e0)), 32'd0);
    send_bits(29'h0000_0ABC, WB, 1'b0);
    chk("mid_rst_word2", 32'(word_out), 32'h0000_0ABC);

    // Full line plus one word, line_start on word 0.
    e0 = n_err;
    for (int k = 0; k <= LW; k++) begin
      w = WB'(k * 32'h0101_0101 + 32'h5);
      send_bits(w, WB, k == 0);
`ifdef G15_WORD_ADDR_EN
      exp_addr = 32'(k % LW);
`else
      exp_addr = 32'h0;
`endif
      chk($sformatf("line_addr_%0d", k), 32'(word_addr), exp_addr);
      if (k == 0 || k == LW - 1 || k == LW) chk($sformatf("line_word_%0d", k), 32'(word_out), 32'(w));
    end
    chk("line_no_err", 32'(n_err - e0), 32'd0);
    chk("never_both", 32'(n_both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
